// File: rtl/alu_pipe_top.sv
// alu_pipe_top: three-stage pipelined register-file / ALU / data-memory datapath.
//   S1 operand read (with forwarding), S2 execute, S3 memory access + writeback.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   in_valid/in_ready   instruction handshake into S1 (in_ready is combinational)
//   ALUSrc, ALUControl, RegWrite, ResultSrc, MemWrite   decoder controls
//   A1, A2, A3, ImmExt  source/destination register indices and extended immediate
//   out_valid, Result, Zero   writeback-stage instruction status (zeroed when idle)
//   a0                  live contents of register A0_IDX
module alu_pipe_top #(
  parameter int unsigned A_WIDTH    = 5,
  parameter int unsigned D_WIDTH    = 32,
  parameter int unsigned MEM_AWIDTH = 8,
  parameter int unsigned A0_IDX     = 10
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               ALUSrc,
  input  logic [3:0]         ALUControl,
  input  logic               RegWrite,
  input  logic [A_WIDTH-1:0] A1,
  input  logic [A_WIDTH-1:0] A2,
  input  logic [A_WIDTH-1:0] A3,
  input  logic [D_WIDTH-1:0] ImmExt,
  input  logic               ResultSrc,
  input  logic               MemWrite,
  output logic               out_valid,
  output logic [D_WIDTH-1:0] Result,
  output logic               Zero,
  output logic [D_WIDTH-1:0] a0
);

  localparam int unsigned SH_W      = $clog2(D_WIDTH);
  localparam int unsigned RF_DEPTH  = 2 ** A_WIDTH;
  localparam int unsigned MEM_DEPTH = 2 ** MEM_AWIDTH;
  localparam logic [A_WIDTH-1:0] A0_SEL = A_WIDTH'(A0_IDX);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLT  = 4'd5,
    OP_SLTU = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9
  } alu_op_e;

  // Execute-stage register: operands already forwarded in S1.
  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic               result_src;
    logic               mem_write;
    logic               alu_src;
    logic [3:0]         alu_ctl;
    logic [A_WIDTH-1:0] a3;
    logic [D_WIDTH-1:0] op_a;
    logic [D_WIDTH-1:0] op_b;
    logic [D_WIDTH-1:0] imm;
  } s2_t;

  // Memory/writeback-stage register.
  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic               result_src;
    logic               mem_write;
    logic [A_WIDTH-1:0] a3;
    logic [D_WIDTH-1:0] alu_res;
    logic               zero;
    logic [D_WIDTH-1:0] store_data;
  } s3_t;

  s2_t s2_q, s2_d;
  s3_t s3_q, s3_d;

  logic [D_WIDTH-1:0] rf_q  [RF_DEPTH];
  logic [D_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic                  load_use;
  logic                  accept;
  logic [D_WIDTH-1:0]    fwd_a;
  logic [D_WIDTH-1:0]    fwd_b;
  logic [D_WIDTH-1:0]    src_b;
  logic [SH_W-1:0]       shamt;
  logic [D_WIDTH-1:0]    alu_y;
  logic                  s2_fwd_ok;
  logic                  s3_fwd_ok;
  logic [MEM_AWIDTH-1:0] mem_addr;
  logic [D_WIDTH-1:0]    read_data;
  logic [D_WIDTH-1:0]    s3_result;
  logic                  rf_we;
  logic                  mem_we;

  // ---------------------------------------------------------------- S1
  // A load in S2 cannot forward yet; both sources are compared even when
  // SrcB will come from the immediate.
  always_comb begin
    load_use = s2_q.valid && s2_q.reg_write && s2_q.result_src &&
               (s2_q.a3 != '0) && ((s2_q.a3 == A1) || (s2_q.a3 == A2));
    in_ready = RST || !load_use;
    accept   = in_valid && in_ready && !RST;
  end

  // Priority: S2 ALU output over S3 result over the register file.
  always_comb begin
    s2_fwd_ok = s2_q.valid && s2_q.reg_write && !s2_q.result_src;
    s3_fwd_ok = s3_q.valid && s3_q.reg_write;

    fwd_a = rf_q[A1];
    if (s3_fwd_ok && (s3_q.a3 == A1)) fwd_a = s3_result;
    if (s2_fwd_ok && (s2_q.a3 == A1)) fwd_a = alu_y;
    if (A1 == '0) fwd_a = '0;

    fwd_b = rf_q[A2];
    if (s3_fwd_ok && (s3_q.a3 == A2)) fwd_b = s3_result;
    if (s2_fwd_ok && (s2_q.a3 == A2)) fwd_b = alu_y;
    if (A2 == '0) fwd_b = '0;
  end

  always_comb begin
    s2_d            = '0;
    s2_d.valid      = accept;
    s2_d.reg_write  = RegWrite;
    s2_d.result_src = ResultSrc;
    s2_d.mem_write  = MemWrite;
    s2_d.alu_src    = ALUSrc;
    s2_d.alu_ctl    = ALUControl;
    s2_d.a3         = A3;
    s2_d.op_a       = fwd_a;
    s2_d.op_b       = fwd_b;
    s2_d.imm        = ImmExt;
  end

  // ---------------------------------------------------------------- S2
  always_comb begin
    src_b = s2_q.alu_src ? s2_q.imm : s2_q.op_b;
    shamt = src_b[SH_W-1:0];
    case (s2_q.alu_ctl)
      OP_ADD:  alu_y = s2_q.op_a + src_b;
      OP_SUB:  alu_y = s2_q.op_a - src_b;
      OP_AND:  alu_y = s2_q.op_a & src_b;
      OP_OR:   alu_y = s2_q.op_a | src_b;
      OP_XOR:  alu_y = s2_q.op_a ^ src_b;
      OP_SLT:  alu_y = {{(D_WIDTH-1){1'b0}}, ($signed(s2_q.op_a) < $signed(src_b))};
      OP_SLTU: alu_y = {{(D_WIDTH-1){1'b0}}, (s2_q.op_a < src_b)};
      OP_SLL:  alu_y = s2_q.op_a << shamt;
      OP_SRL:  alu_y = s2_q.op_a >> shamt;
      OP_SRA:  alu_y = D_WIDTH'($signed(s2_q.op_a) >>> shamt);
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    s3_d            = '0;
    s3_d.valid      = s2_q.valid;
    s3_d.reg_write  = s2_q.reg_write;
    s3_d.result_src = s2_q.result_src;
    s3_d.mem_write  = s2_q.mem_write;
    s3_d.a3         = s2_q.a3;
    s3_d.alu_res    = alu_y;
    s3_d.zero       = (alu_y == '0);
    s3_d.store_data = s2_q.op_b;
  end

  // ---------------------------------------------------------------- S3
  always_comb begin
    mem_addr  = s3_q.alu_res[MEM_AWIDTH+1:2];
    read_data = mem_q[mem_addr];
    s3_result = s3_q.result_src ? read_data : s3_q.alu_res;
    rf_we     = s3_q.valid && s3_q.reg_write && (s3_q.a3 != '0);
    // Reset wins over a store sitting in S3.
    mem_we    = s3_q.valid && s3_q.mem_write && !RST;
  end

  // Outputs are forced quiet while RST is held so the first reset cycle,
  // before the clearing edge, already shows the idle state.
  always_comb begin
    out_valid = s3_q.valid && !RST;
    Result    = out_valid ? s3_result : '0;
    Zero      = out_valid && s3_q.zero;
    a0        = RST ? '0 : rf_q[A0_SEL];
  end

  // ---------------------------------------------------------------- state
  always_ff @(posedge CLK) begin
    if (RST) begin
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rf_q <= '{default: '0};
    end else if (rf_we) begin
      rf_q[s3_q.a3] <= s3_result;
    end
  end

  // Data memory is deliberately left unreset.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[mem_addr] <= s3_q.store_data;
    end
  end

endmodule
